// File: rtl/minibus_arbiter.sv
// minibus_arbiter: round-robin arbiter that shares one minibus slave port
// between NUM_MASTERS minibus masters.
//
// Ports:
//   clk, nrst                   clock, asynchronous active-low reset
//   m_addr/m_wdata/m_width      per-master request fields, master i at slice i
//   m_wen/m_ren                 per-master strobes; held until m_ack[i]
//   m_ack                       one-hot completion pulse to the granted master
//   m_err, m_rdata              response qualifiers, valid with m_ack
//   s_addr/s_wdata/s_width      registered request driven to the slave in BUSY
//   s_wen/s_ren                 slave strobes, active only in BUSY
//   s_ack, s_rdata              slave completion and read data
//
// Each transaction takes IDLE (arbitrate and latch), BUSY (drive the slave
// until ack or timeout) and RESP (one-cycle m_ack). Every output is a decode
// of registered state, so there is no combinational path from m_* to s_* or
// from s_ack to m_ack.
module minibus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT     = 256
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  input  logic [NUM_MASTERS*2-1:0]      m_width,
  input  logic [NUM_MASTERS-1:0]        m_wen,
  input  logic [NUM_MASTERS-1:0]        m_ren,
  output logic [NUM_MASTERS-1:0]        m_ack,
  output logic                          m_err,
  output logic [DATA_W-1:0]             m_rdata,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  output logic [1:0]                    s_width,
  output logic                          s_wen,
  output logic                          s_ren,
  input  logic                          s_ack,
  input  logic [DATA_W-1:0]             s_rdata
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  // The counter only has to reach TIMEOUT-1.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  state_t state_q, state_d;

  logic [IDX_W-1:0]  grant, last_grant, pick;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [1:0]        req_width;
  logic              req_wen, req_ren;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic [CNT_W-1:0]  cnt;

  logic [NUM_MASTERS-1:0] pending;
  logic                   any_pending;
  logic                   timeout_hit;
  logic                   found;
  int                     idx;

  logic [ADDR_W-1:0] addr_a  [NUM_MASTERS];
  logic [DATA_W-1:0] wdata_a [NUM_MASTERS];
  logic [1:0]        width_a [NUM_MASTERS];

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
    assign addr_a[g]  = m_addr[g*ADDR_W +: ADDR_W];
    assign wdata_a[g] = m_wdata[g*DATA_W +: DATA_W];
    assign width_a[g] = m_width[g*2 +: 2];
  end

  assign pending     = m_wen | m_ren;
  assign any_pending = |pending;
  assign timeout_hit = (TIMEOUT != 0) && (cnt == TO_LAST);

  // Round-robin pick: first pending master starting at last_grant+1.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      idx = (int'(last_grant) + k) % NUM_MASTERS;
      if (!found && pending[IDX_W'(idx)]) begin
        pick  = IDX_W'(idx);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_pending) state_d = BUSY;
      // s_ack wins over a coincident timeout; both leave for RESP.
      BUSY:    if (s_ack || timeout_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      grant      <= '0;
      last_grant <= IDX_W'(NUM_MASTERS - 1);
      req_addr   <= '0;
      req_wdata  <= '0;
      req_width  <= '0;
      req_wen    <= 1'b0;
      req_ren    <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      cnt        <= '0;
    end else begin
      case (state_q)
        IDLE: if (any_pending) begin
          grant     <= pick;
          req_addr  <= addr_a[pick];
          req_wdata <= wdata_a[pick];
          req_width <= width_a[pick];
          // Write wins when a master raises both strobes.
          req_wen   <= m_wen[pick];
          req_ren   <= m_ren[pick] & ~m_wen[pick];
          cnt       <= '0;
        end
        BUSY: begin
          if (s_ack) begin
            rsp_rdata <= req_ren ? s_rdata : '0;
            rsp_err   <= 1'b0;
          end else if (timeout_hit) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: last_grant <= grant;
        default: begin
          req_addr  <= '0;
          req_wdata <= '0;
          req_width <= '0;
          req_wen   <= 1'b0;
          req_ren   <= 1'b0;
        end
      endcase
    end
  end

  // Output decodes of registered state only.
  always_comb begin
    s_addr  = '0;
    s_wdata = '0;
    s_width = '0;
    s_wen   = 1'b0;
    s_ren   = 1'b0;
    m_ack   = '0;
    m_err   = 1'b0;
    m_rdata = '0;
    if (state_q == BUSY) begin
      s_addr  = req_addr;
      s_wdata = req_wdata;
      s_width = req_width;
      s_wen   = req_wen;
      s_ren   = req_ren;
    end
    if (state_q == RESP) begin
      m_ack[grant] = 1'b1;
      m_err        = rsp_err;
      m_rdata      = rsp_rdata;
    end
  end

endmodule
